// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer: FSM state encoding,
// forwarding-select codes and register-address width.
package hazard_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Register 0 is never a hazard source/destination when it is hardwired.
  function automatic logic reg_live(input logic [REG_AW-1:0] r, input logic r0_zero);
    return !(r0_zero && (r == '0));
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational decode-stage forwarding selects and load-use detection.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [REG_AW-1:0] A1,
  input  logic [REG_AW-1:0] A2,
  input  logic [REG_AW-1:0] WB1,
  input  logic              writeToRegE,
  input  logic              loadE,
  input  logic [REG_AW-1:0] WB2,
  input  logic              writeToRegM,
  input  logic [REG_AW-1:0] WB3,
  input  logic              writeToRegW,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              lu
);

  // M-stage result is younger than W-stage data, so it wins on a double match.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (!reg_live(src, R0_ZERO))           return FWD_REG;
    else if (writeToRegM && (WB2 == src))  return FWD_MEM;
    else if (writeToRegW && (WB3 == src))  return FWD_WB;
    else                                   return FWD_REG;
  endfunction

  assign ForwardA = fwd_sel(A1);
  assign ForwardB = fwd_sel(A2);

  assign lu = loadE && writeToRegE && reg_live(WB1, R0_ZERO) &&
              ((WB1 == A1) || (WB1 == A2));

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall controller: reset fill, load-use stall, branch/jump flush,
// memory-wait freeze with sticky timeout. Define HAZARD_PERF_EN for perf counters.
//
//  state  | meaning
//  FILL   | post-reset bubbles, FlushD/FlushE forced high
//  RUN    | normal hazard priority decode
//  FREEZE | memory wait, whole pipe stalled; exits on mem_ready
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int RST_BUBBLES = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter bit R0_ZERO     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] A1,
  input  logic [REG_AW-1:0] A2,
  input  logic [REG_AW-1:0] WB1,
  input  logic              writeToRegE,
  input  logic              loadE,
  input  logic [REG_AW-1:0] WB2,
  input  logic              writeToRegM,
  input  logic [REG_AW-1:0] WB3,
  input  logic              writeToRegW,
  input  logic              jump_d,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       perf_stall,
  output logic [15:0]       perf_flush,
  output logic [15:0]       perf_freeze
`endif
);

  localparam logic [2:0] FILL_INIT = 3'(RST_BUBBLES);
  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [2:0] fill_cnt;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mem_wait;

  assign mem_wait = mem_req && !mem_ready;

  hazard_fwd_unit #(.R0_ZERO(R0_ZERO)) u_fwd (
    .A1         (A1),
    .A2         (A2),
    .WB1        (WB1),
    .writeToRegE(writeToRegE),
    .loadE      (loadE),
    .WB2        (WB2),
    .writeToRegM(writeToRegM),
    .WB3        (WB3),
    .writeToRegW(writeToRegW),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .lu         (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (fill_cnt <= 3'd1) state_nxt = RUN;
      RUN:     if (mem_wait)         state_nxt = FREEZE;
      FREEZE:  if (!mem_wait)        state_nxt = RUN;
      default:                       state_nxt = FILL;
    endcase
  end

  // A FREEZE cycle with mem_ready already uses RUN priorities, so a branch held in E is flushed.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (state == FILL || (state != RUN && state != FREEZE)) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (branch_taken) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (jump_d) begin
      FlushD = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= FILL_INIT;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (state == FILL && fill_cnt > 3'd1) fill_cnt <= fill_cnt - 3'd1;
      if (state != FILL && mem_wait) begin
        if (wait_cnt != 8'hFF)         wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt >= TIMEOUT - 8'd1) mem_err  <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_evt, flush_evt, freeze_evt;
  assign freeze_evt = StallM;
  assign stall_evt  = StallF && !StallM;
  assign flush_evt  = FlushD && (state != FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_flush  <= '0;
      perf_freeze <= '0;
    end else begin
      if (stall_evt  && perf_stall  != 16'hFFFF) perf_stall  <= perf_stall  + 16'd1;
      if (flush_evt  && perf_flush  != 16'hFFFF) perf_flush  <= perf_flush  + 16'd1;
      if (freeze_evt && perf_freeze != 16'hFFFF) perf_freeze <= perf_freeze + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (default parameters).
module tb_hazard_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] A1, A2, WB1, WB2, WB3;
  logic       writeToRegE, loadE, writeToRegM, writeToRegW;
  logic       jump_d, branch_taken, mem_req, mem_ready;
  logic [1:0] ForwardA, ForwardB;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall, perf_flush, perf_freeze;
`endif

  hazard_sequencer #(.RST_BUBBLES(2), .MEM_TIMEOUT(15), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .WB1(WB1), .writeToRegE(writeToRegE), .loadE(loadE),
    .WB2(WB2), .writeToRegM(writeToRegM), .WB3(WB3), .writeToRegW(writeToRegW),
    .jump_d(jump_d), .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_freeze(perf_freeze)
`endif
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  wire [5:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    A1 = '0; A2 = '0; WB1 = '0; WB2 = '0; WB3 = '0;
    writeToRegE = 1'b0; loadE = 1'b0; writeToRegM = 1'b0; writeToRegW = 1'b0;
    jump_d = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 16'(ctl), 16'(6'b000011));
    check("rst_err", 16'(mem_err), 16'(1'b0));

    // Two fill bubbles after release
    next_cycle(); rst = 1'b0;
    @(negedge clk); check("fill_1", 16'(ctl), 16'(6'b000011));
    next_cycle();
    @(negedge clk); check("fill_2", 16'(ctl), 16'(6'b000011));
    next_cycle();
    @(negedge clk); check("fill_done", 16'(ctl), 16'(6'b000000));

    // Forwarding
    next_cycle();
    A1 = 3'd3; WB2 = 3'd3; writeToRegM = 1'b1; WB3 = 3'd3; writeToRegW = 1'b1;
    @(negedge clk); check("fwdA_mem", 16'(ForwardA), 16'(2'd1));
    next_cycle(); writeToRegM = 1'b0; A2 = 3'd3;
    @(negedge clk); check("fwdA_wb", 16'(ForwardA), 16'(2'd2));
    check("fwdB_wb", 16'(ForwardB), 16'(2'd2));
    next_cycle(); A2 = 3'd6; WB2 = 3'd6; WB3 = 3'd6; writeToRegM = 1'b1;
    @(negedge clk); check("fwdB_m_beats_w", 16'(ForwardB), 16'(2'd1));
    next_cycle(); A1 = 3'd0; A2 = 3'd0; WB2 = 3'd0; WB3 = 3'd0;
    @(negedge clk); check("fwdA_r0", 16'(ForwardA), 16'(2'd0));
    check("fwdB_r0", 16'(ForwardB), 16'(2'd0));

    // Load-use
    next_cycle(); clear_in();
    loadE = 1'b1; writeToRegE = 1'b1; WB1 = 3'd5; A2 = 3'd5;
    @(negedge clk); check("lu_stall", 16'(ctl), 16'(6'b110001));
    next_cycle(); loadE = 1'b0;
    @(negedge clk); check("lu_clear", 16'(ctl), 16'(6'b000000));
    next_cycle(); loadE = 1'b1; WB1 = 3'd0; A1 = 3'd0; A2 = 3'd0;
    @(negedge clk); check("lu_r0", 16'(ctl), 16'(6'b000000));

    // Branch beats load-use; jump alone
    next_cycle(); WB1 = 3'd5; A1 = 3'd5; branch_taken = 1'b1;
    @(negedge clk); check("br_over_lu", 16'(ctl), 16'(6'b000011));
    next_cycle(); clear_in(); jump_d = 1'b1;
    @(negedge clk); check("jump", 16'(ctl), 16'(6'b000010));

    // Freeze with a held branch
    next_cycle(); clear_in(); mem_req = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check($sformatf("freeze_%0d", i), 16'(ctl), 16'(6'b111100));
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk); check("freeze_exit_br", 16'(ctl), 16'(6'b000011));
    next_cycle(); clear_in();
    @(negedge clk); check("post_freeze", 16'(ctl), 16'(6'b000000));
    check("no_err_short", 16'(mem_err), 16'(1'b0));

    // Timeout: 15 consecutive wait cycles set mem_err
    next_cycle(); mem_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i >= 14) check($sformatf("err_early_%0d", i), 16'(mem_err), 16'(1'b0));
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk); check("err_set", 16'(mem_err), 16'(1'b1));
    check("err_exit_ctl", 16'(ctl), 16'(6'b000000));
    next_cycle(); clear_in();
    @(negedge clk); check("err_sticky", 16'(mem_err), 16'(1'b1));

    // Reset mid-freeze
    next_cycle(); mem_req = 1'b1;
    next_cycle();
    next_cycle(); rst = 1'b1;
    @(negedge clk); check("pre_rst_freeze", 16'(ctl), 16'(6'b111100));
    next_cycle();
    @(negedge clk); check("rst_fill_ctl", 16'(ctl), 16'(6'b000011));
    check("rst_err_clr", 16'(mem_err), 16'(1'b0));
    next_cycle(); rst = 1'b0; clear_in();
    repeat (3) next_cycle();
    @(negedge clk); check("rerun_idle", 16'(ctl), 16'(6'b000000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
